multu_hilo: RTL and testbench
=============================

# multu_hilo

Sequential 32×32 unsigned shift-add multiplier with its HI/LO result register, the MULTU datapath inside TotalALU. It sits between the ALU operand/Signal inputs and the ALU output mux. It starts when Signal carries the MULTU code, iterates one multiplier bit per cycle, and holds the 64-bit product in hi/lo. The output mux reads hi/lo on MFHI/MFLO.

## Interface
- WIDTH, 32, operand width; product is 2*WIDTH
- MULTU_CODE, 6'd25, Signal value that starts a multiply
- clk  input  1  rising-edge clock; single clock domain
- reset  input  1  synchronous, active-low reset (sampled on rising clk edge)
- dataA  input  WIDTH  multiplicand, captured at start
- dataB  input  WIDTH  multiplier, captured at start
- Signal  input  6  ALU function code, same bus that drives the ALU output mux
- hi  output  WIDTH  upper half of the last completed product
- lo  output  WIDTH  lower half of the last completed product
- busy  output  1  high while iterating
- done  output  1  one-cycle pulse when hi/lo are updated

## Operation
- States: IDLE, RUN, HOLD.
- IDLE, Signal==MULTU_CODE at clock edge:
  - mcand <= dataA; prod[2W:0] <= {1'b0, W'b0, dataB}; count <= 0; go to RUN.
- RUN, each edge:
  - If prod[0]==1, add mcand to prod[2W-1:W] with a W+1-bit sum (carry into bit 2W).
  - Shift the whole 2W+1-bit prod right by 1. count <= count+1.
  - After the 32nd iteration, hi <= prod[2W-1:W] and lo <= prod[W-1:0] (post-shift values), done pulses, go to HOLD.
- HOLD:
  - Stay while Signal==MULTU_CODE. This blocks restart while the caller keeps Signal at 25.
  - Go to IDLE on the first edge with Signal!=MULTU_CODE.
- Unsigned only. The product is exact in 2W bits, with no overflow and no flags.
- hi/lo change only at completion or reset. They keep the previous product during RUN, HOLD and IDLE.
- dataA/dataB/Signal changes during RUN are ignored. There is no abort, and the operation always completes.
- Signal values other than MULTU_CODE have no effect on this block. MFHI(16)/MFLO(18) selection is done in the output mux, not here.

## Timing
- Reset (reset==0 at edge): state=IDLE, hi=0, lo=0, busy=0, done=0, count=0, internal regs cleared.
  - Applies mid-RUN: the partial product is discarded and the new hi/lo=0.
- Start edge S (IDLE, Signal==25): busy=1 from after S.
- Iteration edges S+1 … S+32. At S+32, hi/lo are written, busy falls, and done=1 for exactly the cycle after S+32.
- Latency: result visible 32 cycles after the start edge (33 cycles from Signal first sampled). This fits the 33-cycle MULTU window plus a 2-cycle margin before MFHI.
- Start in IDLE and reset in the same edge: reset wins.
- done never asserts twice for one MULTU, however long Signal stays at 25.
- Back-to-back: a new multiply needs ≥1 edge with Signal!=25 (HOLD→IDLE), then Signal==25 (IDLE→RUN). Minimum period is 34 cycles.

## Test plan
- Multiply 3 by 5:
  - Stimulus: reset low 1 cycle; Signal=25, dataA=3, dataB=5 held 35 cycles.
  - Required: done at cycle 33 after start; hi=0, lo=15.
- Maximum operands:
  - Stimulus: dataA=dataB=32'hFFFFFFFF.
  - Required: hi=32'hFFFFFFFE, lo=32'h00000001. This checks the carry bit 2W.
- Zero operand and operand change mid-run:
  - Stimulus: dataA=0, dataB=123456; after start, change dataA to 7 during RUN.
  - Required: hi=0, lo=0. The operand change is ignored.
- Held Signal:
  - Stimulus: Signal held at 25 for 80 cycles with dataA=2, dataB=3.
  - Required: exactly one done pulse; hi=0, lo=6; busy low from cycle 33 onward.
- Reset mid-run:
  - Stimulus: after a completed 100×100 (lo=10000), start 7×9 and pull reset low at iteration 10.
  - Required: hi=lo=0, busy=0, IDLE.
  - Then Signal=25 restarts, giving lo=63 after 32 iterations.
- Back-to-back with MFHI/MFLO interleave:
  - Stimulus: 65536×65536, then Signal=16, 18, then 25 with 10×20.
  - Required: hi=1, lo=0, then hi=0, lo=200.
  - hi/lo unchanged during the MFHI/MFLO cycles.

Source files
------------

// File: rtl/multu_hilo.sv
// multu_hilo: sequential 32x32 unsigned shift-add multiplier holding its
// 64-bit product in the HI/LO register pair. A multiply starts when Signal
// carries the MULTU code, retires one multiplier bit per cycle and publishes
// hi/lo with a one-cycle done pulse after the last iteration.
module multu_hilo #(
    parameter int         WIDTH      = 32,
    parameter logic [5:0] MULTU_CODE = 6'd25
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    input  logic [5:0]       Signal,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [WIDTH-1:0]    mcand;
    logic [2*WIDTH:0]    prod;
    logic [2*WIDTH:0]    prod_step;
    logic [CW-1:0]       count;
    logic                start;
    logic                last;

    // One shift-add iteration: conditionally add the multiplicand into the
    // upper half (W+1-bit sum keeps the carry), then shift everything right.
    function automatic logic [2*WIDTH:0] shift_add_step(
        input logic [2*WIDTH:0] p,
        input logic [WIDTH-1:0] m
    );
        logic [WIDTH:0] sum;
        sum = p[2*WIDTH:WIDTH] + {1'b0, (p[0] ? m : {WIDTH{1'b0}})};
        return {1'b0, sum, p[WIDTH-1:1]};
    endfunction

    assign start     = (state == IDLE) && (Signal == MULTU_CODE);
    assign last      = (state == RUN) && (count == CW'(WIDTH - 1));
    assign prod_step = shift_add_step(prod, mcand);

    // State register; reset returns to IDLE and takes priority over a start.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and busy decode; HOLD blocks a restart while Signal stays at MULTU.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                if (Signal == MULTU_CODE) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (Signal != MULTU_CODE) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath: capture operands at start, iterate in RUN, publish hi/lo on the last step.
    always_ff @(posedge clk) begin
        if (!reset) begin
            mcand <= '0;
            prod  <= '0;
            count <= '0;
            hi    <= '0;
            lo    <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                mcand <= dataA;
                prod  <= {1'b0, {WIDTH{1'b0}}, dataB};
                count <= '0;
            end else if (state == RUN) begin
                prod  <= prod_step;
                count <= count + CW'(1);
                if (last) begin
                    hi   <= prod_step[2*WIDTH-1:WIDTH];
                    lo   <= prod_step[WIDTH-1:0];
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_multu_hilo.sv
// tb_multu_hilo: directed checks of the MULTU datapath with hand-computed products.
module tb_multu_hilo;

    logic        clk;
    logic        reset;
    logic [31:0] dataA;
    logic [31:0] dataB;
    logic [5:0]  Signal;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    multu_hilo #(.WIDTH(32), .MULTU_CODE(6'd25)) dut (
        .clk    (clk),
        .reset  (reset),
        .dataA  (dataA),
        .dataB  (dataB),
        .Signal (Signal),
        .hi     (hi),
        .lo     (lo),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leave HOLD, then present the operands and take the start edge.
    task automatic start_mult(input logic [31:0] a, input logic [31:0] b);
        Signal = 6'd0;
        tick();
        dataA  = a;
        dataB  = b;
        Signal = 6'd25;
        tick();
    endtask

    // Count edges after the start edge until done is seen; -1 on timeout.
    task automatic wait_done(output int lat);
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset  = 1'b0;
        Signal = 6'd0;
        dataA  = '0;
        dataB  = '0;
        tick();
        tick();
        reset = 1'b1;
        checks++;
        if ({hi, lo} !== 64'd0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: hi=%h lo=%h busy=%b done=%b, required 0 0 0 0", hi, lo, busy, done);
        end
    endtask

    task automatic test_3x5();
        int lat;
        start_mult(32'd3, 32'd5);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_after_start: busy=%b, required 1", busy);
        end
        wait_done(lat);
        checks++;
        if (lat !== 32) begin
            errors++;
            $display("FAIL latency_3x5: done after %0d edges, required 32", lat);
        end
        checks++;
        if (hi !== 32'd0 || lo !== 32'd15 || busy !== 1'b0) begin
            errors++;
            $display("FAIL result_3x5: hi=%h lo=%h busy=%b, required 0 f 0", hi, lo, busy);
        end
        tick();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL done_width: done=%b on second cycle, required 0", done);
        end
    endtask

    task automatic test_max();
        int lat;
        start_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(lat);
        checks++;
        if (lat !== 32 || hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001) begin
            errors++;
            $display("FAIL max_operands: lat=%0d hi=%h lo=%h, required 32 fffffffe 00000001", lat, hi, lo);
        end
        start_mult(32'hFFFF_FFFF, 32'd2);
        wait_done(lat);
        checks++;
        if (hi !== 32'h0000_0001 || lo !== 32'hFFFF_FFFE) begin
            errors++;
            $display("FAIL max_times_two: hi=%h lo=%h, required 00000001 fffffffe", hi, lo);
        end
    endtask

    task automatic test_zero_change();
        int lat;
        start_mult(32'd0, 32'd123456);
        tick();
        tick();
        dataA  = 32'd7;
        dataB  = 32'd9;
        Signal = 6'd16;
        tick();
        checks++;
        if (busy !== 1'b1 || hi !== 32'h0000_0001 || lo !== 32'hFFFF_FFFE) begin
            errors++;
            $display("FAIL hilo_hold_in_run: busy=%b hi=%h lo=%h, required 1 00000001 fffffffe", busy, hi, lo);
        end
        wait_done(lat);
        checks++;
        if (lat !== 29 || hi !== 32'd0 || lo !== 32'd0) begin
            errors++;
            $display("FAIL zero_operand: lat=%0d hi=%h lo=%h, required 29 0 0", lat, hi, lo);
        end
    endtask

    task automatic test_held_signal();
        int pulses;
        int busy_bad;
        pulses   = 0;
        busy_bad = 0;
        start_mult(32'd2, 32'd3);
        for (int i = 1; i <= 80; i++) begin
            tick();
            if (done) pulses++;
            if (i >= 32 && busy) busy_bad++;
        end
        checks++;
        if (pulses !== 1) begin
            errors++;
            $display("FAIL held_done_count: %0d pulses, required 1", pulses);
        end
        checks++;
        if (busy_bad !== 0 || hi !== 32'd0 || lo !== 32'd6) begin
            errors++;
            $display("FAIL held_result: busy_high_cycles=%0d hi=%h lo=%h, required 0 0 6", busy_bad, hi, lo);
        end
    endtask

    task automatic test_reset_mid_run();
        int lat;
        start_mult(32'd100, 32'd100);
        wait_done(lat);
        checks++;
        if (hi !== 32'd0 || lo !== 32'd10000) begin
            errors++;
            $display("FAIL result_100x100: hi=%h lo=%0d, required 0 10000", hi, lo);
        end
        start_mult(32'd7, 32'd9);
        for (int i = 1; i < 10; i++) tick();
        checks++;
        if (busy !== 1'b1 || lo !== 32'd10000) begin
            errors++;
            $display("FAIL pre_reset_run: busy=%b lo=%0d, required 1 10000", busy, lo);
        end
        reset = 1'b0;
        tick();
        reset = 1'b1;
        checks++;
        if ({hi, lo} !== 64'd0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL mid_run_reset: hi=%h lo=%h busy=%b done=%b, required 0 0 0 0", hi, lo, busy, done);
        end
        tick();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL restart_after_reset: busy=%b, required 1", busy);
        end
        wait_done(lat);
        checks++;
        if (lat !== 32 || hi !== 32'd0 || lo !== 32'd63) begin
            errors++;
            $display("FAIL result_7x9: lat=%0d hi=%h lo=%0d, required 32 0 63", lat, hi, lo);
        end
    endtask

    task automatic test_reset_vs_start();
        Signal = 6'd0;
        tick();
        Signal = 6'd25;
        dataA  = 32'd5;
        dataB  = 32'd5;
        reset  = 1'b0;
        tick();
        reset  = 1'b1;
        Signal = 6'd0;
        checks++;
        if (busy !== 1'b0 || {hi, lo} !== 64'd0) begin
            errors++;
            $display("FAIL reset_beats_start: busy=%b hi=%h lo=%h, required 0 0 0", busy, hi, lo);
        end
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL no_start_after_reset: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        start_mult(32'd65536, 32'd65536);
        wait_done(lat);
        checks++;
        if (hi !== 32'd1 || lo !== 32'd0) begin
            errors++;
            $display("FAIL result_2p32: hi=%h lo=%h, required 1 0", hi, lo);
        end
        Signal = 6'd16;
        tick();
        checks++;
        if (hi !== 32'd1 || lo !== 32'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mfhi_cycle: hi=%h lo=%h busy=%b, required 1 0 0", hi, lo, busy);
        end
        Signal = 6'd18;
        tick();
        checks++;
        if (hi !== 32'd1 || lo !== 32'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mflo_cycle: hi=%h lo=%h busy=%b, required 1 0 0", hi, lo, busy);
        end
        dataA  = 32'd10;
        dataB  = 32'd20;
        Signal = 6'd25;
        tick();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_start: busy=%b, required 1", busy);
        end
        wait_done(lat);
        checks++;
        if (lat !== 32 || hi !== 32'd0 || lo !== 32'd200) begin
            errors++;
            $display("FAIL result_10x20: lat=%0d hi=%h lo=%0d, required 32 0 200", lat, hi, lo);
        end
    endtask

    initial begin
        test_reset();
        test_3x5();
        test_max();
        test_zero_change();
        test_held_signal();
        test_reset_mid_run();
        test_reset_vs_start();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
